// File: rtl/ycbcr_rng_pkg.sv
// Shared definitions for the YCbCr nominal-range stream path: state encoding,
// converter constants and counter-width helpers.
package ycbcr_rng_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    localparam logic [7:0]  Y_MAX   = 8'd235;
    localparam logic [7:0]  C_MAX   = 8'd240;
    localparam logic [9:0]  Y_GAIN  = 10'd879;
    localparam logic [9:0]  C_GAIN  = 10'd900;
    localparam logic [17:0] RND_OFS = 18'd16896;

    function automatic int f_clog2(input int n);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < n) begin
            p = p * 2;
            r = r + 1;
        end
        return r;
    endfunction

    // A counter needs at least one bit even when it only ever holds zero.
    function automatic int f_cnt_width(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return f_clog2(n);
        end
    endfunction

endpackage

// File: rtl/ycbcr_rng_stream_ctrl_nominal_rng.sv
// Combinational 3-channel full-range to nominal-range (Y 16..235, C 16..240)
// converter.
module ycbcr_nominal_rng
    import ycbcr_rng_pkg::*;
(
    input  logic [7:0] y,
    input  logic [7:0] cb,
    input  logic [7:0] cr,
    output logic [7:0] y_rng,
    output logic [7:0] cb_rng,
    output logic [7:0] cr_rng
);

    // Scale by gain/1024 with a +16.5 offset folded into RND_OFS, then clamp.
    function automatic logic [7:0] f_scale(input logic [7:0] v,
                                           input logic [9:0] gain,
                                           input logic [7:0] lim);
        logic [17:0] acc;
        logic [7:0]  q;
        acc = 18'(v) * 18'(gain) + RND_OFS;
        q   = 8'(acc >> 10);
        if (q > lim) begin
            return lim;
        end else begin
            return q;
        end
    endfunction

    // Per-channel conversion
    always_comb begin
        y_rng  = f_scale(y,  Y_GAIN, Y_MAX);
        cb_rng = f_scale(cb, C_GAIN, C_MAX);
        cr_rng = f_scale(cr, C_GAIN, C_MAX);
    end

endmodule

// File: rtl/ycbcr_rng_stream_ctrl.sv
// Frame-aware stream controller: per-frame range/bypass selection, line and
// pixel tracking, one elastic output register and frame-length checking.
module ycbcr_rng_stream_ctrl
    import ycbcr_rng_pkg::*;
#(
    parameter int HSIZE = 1920,
    parameter int VSIZE = 1080
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rng_en,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_sof,
    input  logic [7:0] i_y,
    input  logic [7:0] i_cb,
    input  logic [7:0] i_cr,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_y,
    output logic [7:0] o_cb,
    output logic [7:0] o_cr,
    output logic       o_sof,
    output logic       o_eol,
    output logic       o_eof,
    output logic       o_busy,
    output logic       o_len_err
);

    localparam int XW = f_cnt_width(HSIZE);
    localparam int YW = f_cnt_width(VSIZE);
    localparam logic [XW-1:0] X_LAST = XW'(HSIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VSIZE - 1);

    state_t        state_r;
    state_t        state_s;
    logic [XW-1:0] xcnt_r;
    logic [YW-1:0] ycnt_r;
    logic          mode_r;
    logic          mode_s;
    logic          after_eof_r;
    logic          len_err_r;
    logic          accept_s;
    logic          line_end_s;
    logic          frame_end_s;
    logic          fwd_s;
    logic          start_s;
    logic          early_s;
    logic          late_s;
    logic          eol_s;
    logic          eof_s;
    logic [7:0]    y_rng_s;
    logic [7:0]    cb_rng_s;
    logic [7:0]    cr_rng_s;
    logic [7:0]    y_mux_s;
    logic [7:0]    cb_mux_s;
    logic [7:0]    cr_mux_s;
    logic          valid_r;
    logic [7:0]    out_y_r;
    logic [7:0]    out_cb_r;
    logic [7:0]    out_cr_r;
    logic          out_sof_r;
    logic          out_eol_r;
    logic          out_eof_r;

    ycbcr_nominal_rng u_rng (
        .y      (i_y),
        .cb     (i_cb),
        .cr     (i_cr),
        .y_rng  (y_rng_s),
        .cb_rng (cb_rng_s),
        .cr_rng (cr_rng_s)
    );

    assign o_ready     = ~valid_r | i_ready;
    assign accept_s    = i_valid & o_ready;
    assign line_end_s  = (xcnt_r == X_LAST);
    assign frame_end_s = line_end_s & (ycnt_r == Y_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && i_sof) begin
                    state_s = ST_ACTIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (accept_s && !i_sof && frame_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ACTIVE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Per-beat control decode: forward, frame start, markers and error causes
    always_comb begin
        fwd_s   = 1'b0;
        start_s = 1'b0;
        early_s = 1'b0;
        late_s  = 1'b0;
        eol_s   = 1'b0;
        eof_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && i_sof) begin
                    fwd_s   = 1'b1;
                    start_s = 1'b1;
                end else if (accept_s) begin
                    late_s = after_eof_r;
                end else begin
                    fwd_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (accept_s && i_sof) begin
                    fwd_s   = 1'b1;
                    start_s = 1'b1;
                    early_s = (xcnt_r != {XW{1'b0}}) | (ycnt_r != {YW{1'b0}});
                end else if (accept_s) begin
                    fwd_s = 1'b1;
                    eol_s = line_end_s;
                    eof_s = frame_end_s;
                end else begin
                    fwd_s = 1'b0;
                end
            end
            default: fwd_s = 1'b0;
        endcase
    end

    assign o_busy = (state_r == ST_ACTIVE);

    // The sof beat itself already uses the newly requested mode.
    assign mode_s   = start_s ? i_rng_en : mode_r;
    assign y_mux_s  = mode_s ? y_rng_s  : i_y;
    assign cb_mux_s = mode_s ? cb_rng_s : i_cb;
    assign cr_mux_s = mode_s ? cr_rng_s : i_cr;

    // Pixel/line counters hold the position of the next expected beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xcnt_r <= {XW{1'b0}};
            ycnt_r <= {YW{1'b0}};
        end else if (start_s) begin
            xcnt_r <= XW'(1);
            ycnt_r <= {YW{1'b0}};
        end else if (fwd_s && line_end_s) begin
            xcnt_r <= {XW{1'b0}};
            ycnt_r <= frame_end_s ? {YW{1'b0}} : ycnt_r + YW'(1);
        end else if (fwd_s) begin
            xcnt_r <= xcnt_r + XW'(1);
        end
    end

    // Frame mode latch, sticky length error and post-eof tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r      <= 1'b0;
            len_err_r   <= 1'b0;
            after_eof_r <= 1'b0;
        end else if (start_s) begin
            mode_r      <= i_rng_en;
            len_err_r   <= early_s;
            after_eof_r <= 1'b0;
        end else begin
            if (late_s) begin
                len_err_r <= 1'b1;
            end
            if (eof_s) begin
                after_eof_r <= 1'b1;
            end
        end
    end

    // Elastic output register: load on forward, drain on downstream accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            out_y_r   <= 8'd0;
            out_cb_r  <= 8'd0;
            out_cr_r  <= 8'd0;
            out_sof_r <= 1'b0;
            out_eol_r <= 1'b0;
            out_eof_r <= 1'b0;
        end else if (fwd_s) begin
            valid_r   <= 1'b1;
            out_y_r   <= y_mux_s;
            out_cb_r  <= cb_mux_s;
            out_cr_r  <= cr_mux_s;
            out_sof_r <= start_s;
            out_eol_r <= eol_s;
            out_eof_r <= eof_s;
        end else if (i_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign o_valid   = valid_r;
    assign o_y       = out_y_r;
    assign o_cb      = out_cb_r;
    assign o_cr      = out_cr_r;
    assign o_sof     = out_sof_r;
    assign o_eol     = out_eol_r;
    assign o_eof     = out_eof_r;
    assign o_len_err = len_err_r;

endmodule

// File: tb/tb_ycbcr_rng_stream_ctrl.sv
// Scoreboard bench for ycbcr_rng_stream_ctrl with a 4x2 frame geometry.
module tb_ycbcr_rng_stream_ctrl;

    localparam int HS = 4;
    localparam int VS = 2;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       sof;
        logic       eol;
        logic       eof;
        logic       err;
    } beat_t;

    localparam logic [7:0] IY  [8] = '{8'd0, 8'd255, 8'd128, 8'd16, 8'd235, 8'd100, 8'd200, 8'd1};
    localparam logic [7:0] ICB [8] = '{8'd0, 8'd255, 8'd128, 8'd16, 8'd235, 8'd100, 8'd200, 8'd2};
    localparam logic [7:0] ICR [8] = '{8'd0, 8'd255, 8'd128, 8'd16, 8'd235, 8'd100, 8'd200, 8'd3};
    localparam logic [7:0] CY  [8] = '{8'd16, 8'd235, 8'd126, 8'd30, 8'd218, 8'd102, 8'd188, 8'd17};
    localparam logic [7:0] CCB [8] = '{8'd16, 8'd240, 8'd129, 8'd30, 8'd223, 8'd104, 8'd192, 8'd18};
    localparam logic [7:0] CCR [8] = '{8'd16, 8'd240, 8'd129, 8'd30, 8'd223, 8'd104, 8'd192, 8'd19};

    logic       clk;
    logic       rst_n;
    logic       i_rng_en;
    logic       i_valid;
    logic       o_ready;
    logic       i_sof;
    logic [7:0] i_y;
    logic [7:0] i_cb;
    logic [7:0] i_cr;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_y;
    logic [7:0] o_cb;
    logic [7:0] o_cr;
    logic       o_sof;
    logic       o_eol;
    logic       o_eof;
    logic       o_busy;
    logic       o_len_err;

    int    checks;
    int    errors;
    beat_t sb[$];
    beat_t mon_exp;

    ycbcr_rng_stream_ctrl #(.HSIZE(HS), .VSIZE(VS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rng_en  (i_rng_en),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_sof     (i_sof),
        .i_y       (i_y),
        .i_cb      (i_cb),
        .i_cr      (i_cr),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_y       (o_y),
        .o_cb      (o_cb),
        .o_cr      (o_cr),
        .o_sof     (o_sof),
        .o_eol     (o_eol),
        .o_eof     (o_eof),
        .o_busy    (o_busy),
        .o_len_err (o_len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: every beat taken downstream is checked against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat act=%h exp=none",
                         {o_y, o_cb, o_cr, o_sof, o_eol, o_eof, o_len_err});
            end else begin
                mon_exp = sb.pop_front();
                chk("beat", {4'd0, o_y, o_cb, o_cr, o_sof, o_eol, o_eof, o_len_err},
                    {4'd0, mon_exp});
            end
        end
    end

    // Present one input beat until accepted; push its expected output if forwarded
    task automatic send(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                        input logic sof, input logic en, input logic fwd, input beat_t exp);
        int w;
        w = 0;
        i_valid  = 1'b1;
        i_y      = y;
        i_cb     = cb;
        i_cr     = cr;
        i_sof    = sof;
        i_rng_en = en;
        @(negedge clk);
        while (!o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout act=%0d exp=<50", w);
        end else if (fwd) begin
            sb.push_back(exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic frame_beat(input int i, input bit conv, input bit en, input bit err);
        beat_t e;
        e.y   = conv ? CY[i]  : IY[i];
        e.cb  = conv ? CCB[i] : ICB[i];
        e.cr  = conv ? CCR[i] : ICR[i];
        e.sof = (i == 0);
        e.eol = ((i % HS) == HS - 1);
        e.eof = (i == HS * VS - 1);
        e.err = err;
        send(IY[i], ICB[i], ICR[i], (i == 0), en, 1'b1, e);
    endtask

    initial begin
        int w;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_sof    = 1'b0;
        i_rng_en = 1'b0;
        i_y      = 8'd0;
        i_cb     = 8'd0;
        i_cr     = 8'd0;
        i_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_pix", {o_y, o_cb, o_cr}, 0);
        chk("rst_flags", {o_sof, o_eol, o_eof, o_busy, o_len_err}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", o_ready, 1);

        // Converted frame
        for (int i = 0; i < 8; i++) begin
            frame_beat(i, 1'b1, 1'b1, 1'b0);
            if (i == 0) chk("busy_active", o_busy, 1);
        end
        chk("busy_after_eof", o_busy, 0);

        // Bypass frame; the mid-frame request must not take effect
        for (int i = 0; i < 8; i++) frame_beat(i, 1'b0, (i >= 4), 1'b0);
        for (int i = 0; i < 8; i++) frame_beat(i, 1'b1, 1'b1, 1'b0);

        // Beats after eof without sof are dropped and flagged
        for (int i = 0; i < 3; i++) send(8'd50, 8'd50, 8'd50, 1'b0, 1'b1, 1'b0, '0);
        chk("drop_valid", o_valid, 0);
        chk("late_err", o_len_err, 1);
        chk("drop_busy", o_busy, 0);

        // Downstream stall for three cycles mid-line
        fork
            begin
                for (int i = 0; i < 8; i++) frame_beat(i, 1'b1, 1'b1, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                i_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_ready", o_ready, 0);
                    chk("stall_hold", {o_y, o_cb, o_cr, o_sof, o_eol, o_eof},
                        {CY[2], CCB[2], CCR[2], 3'b000});
                end
                @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join

        // Early sof at x=2 of line 1, then a clean frame clears the error
        for (int i = 0; i < 6; i++) frame_beat(i, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) frame_beat(i, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) frame_beat(i, 1'b1, 1'b1, 1'b0);

        // Reset mid-frame with a beat held in the output register
        for (int i = 0; i < 3; i++) frame_beat(i, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_valid", o_valid, 1);
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_pix", {o_y, o_cb, o_cr}, 0);
        chk("mid_rst_flags", {o_sof, o_eol, o_eof, o_busy, o_len_err}, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) send(8'd77, 8'd77, 8'd77, 1'b0, 1'b1, 1'b0, '0);
        chk("post_rst_drop_valid", o_valid, 0);
        chk("post_rst_err", o_len_err, 0);
        chk("post_rst_busy", o_busy, 0);
        for (int i = 0; i < 8; i++) frame_beat(i, 1'b1, 1'b1, 1'b0);

        i_valid = 1'b0;
        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
